mc_ctrl: RTL and testbench

Multi-cycle control sequencer for the MIPS core. It replaces the single-cycle combinational decoder with a Moore state machine that drives the shared datapath (PC, instruction register, register file, ALU, data memory) across FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK steps, so that one ALU and one memory port serve each instruction over several cycles. It sits between the instruction register and every datapath write-enable and mux select.

---
 rtl/mc_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_mc_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
`timescale 1ns/1ps
// mc_ctrl: multi-cycle Moore control sequencer for the MIPS core.
// Walks each instruction through FETCH/DECODE/EXEC/MEMRD/MEMWR/WB/BRANCH/JUMP
// so that a single ALU and one memory port serve the whole instruction.
// Datapath controls decode combinationally from the current state, op and
// funct. Only the state register and the sticky illegal flag are flops.
// Optional feature macro: MC_CTRL_STALL_EN. When it is defined, the
// controller waits in MEMRD/MEMWR until memRdy is high.
module mc_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       memRdy,
  output logic       pcWr,
  output logic [1:0] pcSrc,
  output logic       irWr,
  output logic       regWr,
  output logic [1:0] regDst,
  output logic [1:0] memtoReg,
  output logic       memWr,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] immExt,
  output logic [3:0] aluCtr,
  output logic [2:0] state,
  output logic       instRet,
  output logic       illegal
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEMRD  = 3'd3,
    S_MEMWR  = 3'd4,
    S_WB     = 3'd5,
    S_BRANCH = 3'd6,
    S_JUMP   = 3'd7
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_SLT = 4'b0100;
  localparam logic [3:0] ALU_SLL = 4'b0101;
  localparam logic [3:0] ALU_SRL = 4'b0110;

  state_t cur_state;
  logic   illegal_q;

  logic is_rtype, is_shift, is_jr, is_r_alu;
  logic is_addiu, is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal;
  logic is_supported;
  logic [3:0] alu_sel;

  // Instruction class decode from the opcode and function fields
  assign is_rtype = (op == OP_RTYPE);
  assign is_shift = is_rtype && ((funct == FN_SLL) || (funct == FN_SRL));
  assign is_jr    = is_rtype && (funct == FN_JR);
  assign is_r_alu = is_rtype && ((funct == FN_ADDU) || (funct == FN_SUBU) ||
                                 (funct == FN_AND)  || (funct == FN_OR)   ||
                                 (funct == FN_SLT)  || is_shift);
  assign is_addiu = (op == OP_ADDIU);
  assign is_ori   = (op == OP_ORI);
  assign is_lui   = (op == OP_LUI);
  assign is_lw    = (op == OP_LW);
  assign is_sw    = (op == OP_SW);
  assign is_beq   = (op == OP_BEQ);
  assign is_j     = (op == OP_J);
  assign is_jal   = (op == OP_JAL);
  assign is_supported = is_r_alu || is_jr || is_addiu || is_ori || is_lui ||
                        is_lw || is_sw || is_beq || is_j || is_jal;

  // ALU operation selected for the EXEC step of the current instruction
  always_comb begin
    alu_sel = ALU_ADD;
    if (is_rtype) begin
      case (funct)
        FN_SUBU: alu_sel = ALU_SUB;
        FN_AND:  alu_sel = ALU_AND;
        FN_OR:   alu_sel = ALU_OR;
        FN_SLT:  alu_sel = ALU_SLT;
        FN_SLL:  alu_sel = ALU_SLL;
        FN_SRL:  alu_sel = ALU_SRL;
        default: alu_sel = ALU_ADD;
      endcase
    end else if (is_ori) begin
      alu_sel = ALU_OR;
    end
  end

  // State sequencing and the sticky illegal-instruction flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_state <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      case (cur_state)
        S_FETCH: cur_state <= S_DECODE;
        S_DECODE: begin
          if (!is_supported) begin
            cur_state <= S_FETCH;
            illegal_q <= 1'b1;
          end else if (is_beq) begin
            cur_state <= S_BRANCH;
          end else if (is_j || is_jal || is_jr) begin
            cur_state <= S_JUMP;
          end else begin
            cur_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (is_lw)      cur_state <= S_MEMRD;
          else if (is_sw) cur_state <= S_MEMWR;
          else            cur_state <= S_WB;
        end
`ifdef MC_CTRL_STALL_EN
        S_MEMRD: if (memRdy) cur_state <= S_WB;
        S_MEMWR: if (memRdy) cur_state <= S_FETCH;
`else
        S_MEMRD: cur_state <= S_WB;
        S_MEMWR: cur_state <= S_FETCH;
`endif
        default: cur_state <= S_FETCH;
      endcase
    end
  end

`ifndef MC_CTRL_STALL_EN
  // memRdy only matters when memory stalls are enabled
  logic unused_mem_rdy;
  assign unused_mem_rdy = memRdy;
`endif

  assign state   = cur_state;
  assign illegal = illegal_q;

  // Moore output decode: every control defaults to 0 outside its state
  always_comb begin
    pcWr     = 1'b0;
    pcSrc    = 2'b00;
    irWr     = 1'b0;
    regWr    = 1'b0;
    regDst   = 2'b00;
    memtoReg = 2'b00;
    memWr    = 1'b0;
    aluSrcA  = 1'b0;
    aluSrcB  = 2'b00;
    immExt   = 2'b00;
    aluCtr   = ALU_ADD;
    instRet  = 1'b0;
    case (cur_state)
      S_FETCH: begin
        irWr = 1'b1;
        pcWr = 1'b1;
      end
      S_DECODE: begin
        instRet = !is_supported;
      end
      S_EXEC: begin
        aluCtr  = alu_sel;
        aluSrcA = is_shift;
        if (!is_rtype) begin
          aluSrcB = 2'b01;
          if (is_lui)      immExt = 2'b10;
          else if (is_ori) immExt = 2'b00;
          else             immExt = 2'b01;
        end
      end
      S_MEMWR: begin
        memWr = 1'b1;
`ifdef MC_CTRL_STALL_EN
        instRet = memRdy;
`else
        instRet = 1'b1;
`endif
      end
      S_WB: begin
        regWr    = 1'b1;
        regDst   = is_rtype ? 2'b01 : 2'b00;
        memtoReg = is_lw ? 2'b01 : 2'b00;
        instRet  = 1'b1;
      end
      S_BRANCH: begin
        aluCtr  = ALU_SUB;
        pcSrc   = 2'b01;
        pcWr    = zero;
        instRet = 1'b1;
      end
      S_JUMP: begin
        pcWr    = 1'b1;
        pcSrc   = is_jr ? 2'b11 : 2'b10;
        instRet = 1'b1;
        if (is_jal) begin
          regWr    = 1'b1;
          regDst   = 2'b10;
          memtoReg = 2'b10;
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl.sv
`timescale 1ns/1ps
// tb_mc_ctrl: randomized scoreboard bench for the multi-cycle controller.
// Each issued instruction pushes its expected per-cycle control vectors into
// a queue; a monitor pops one vector per cycle and compares it with the DUT.
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       memRdy;
  logic       pcWr;
  logic [1:0] pcSrc;
  logic       irWr;
  logic       regWr;
  logic [1:0] regDst;
  logic [1:0] memtoReg;
  logic       memWr;
  logic       aluSrcA;
  logic [1:0] aluSrcB;
  logic [1:0] immExt;
  logic [3:0] aluCtr;
  logic [2:0] state;
  logic       instRet;
  logic       illegal;

  mc_ctrl dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
    .memRdy(memRdy), .pcWr(pcWr), .pcSrc(pcSrc), .irWr(irWr),
    .regWr(regWr), .regDst(regDst), .memtoReg(memtoReg), .memWr(memWr),
    .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .immExt(immExt), .aluCtr(aluCtr),
    .state(state), .instRet(instRet), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Instruction descriptor table; kind 16 is an unsupported encoding
  localparam int K_JR = 7, K_LW = 11, K_SW = 12, K_BEQ = 13, K_J = 14, K_JAL = 15, K_ILL = 16;
  string      nm_tab  [17] = '{"addu","subu","and","or","slt","sll","srl","jr",
                               "addiu","ori","lui","lw","sw","beq","j","jal","illegal"};
  logic [5:0] op_tab  [17] = '{6'h00,6'h00,6'h00,6'h00,6'h00,6'h00,6'h00,6'h00,
                               6'h09,6'h0D,6'h0F,6'h23,6'h2B,6'h04,6'h02,6'h03,6'h3F};
  logic [5:0] fn_tab  [17] = '{6'h21,6'h23,6'h24,6'h25,6'h2A,6'h00,6'h02,6'h08,
                               6'h00,6'h00,6'h00,6'h00,6'h00,6'h00,6'h00,6'h00,6'h00};
  logic [3:0] alu_tab [17] = '{4'd0,4'd1,4'd2,4'd3,4'd4,4'd5,4'd6,4'd0,
                               4'd0,4'd3,4'd0,4'd0,4'd0,4'd0,4'd0,4'd0,4'd0};
  logic [1:0] imm_tab [17] = '{2'd0,2'd0,2'd0,2'd0,2'd0,2'd0,2'd0,2'd0,
                               2'd1,2'd0,2'd2,2'd1,2'd1,2'd0,2'd0,2'd0,2'd0};
  logic [5:0] bad_op  [5]  = '{6'h3F,6'h08,6'h05,6'h20,6'h0A};
  logic [5:0] bad_fn  [4]  = '{6'h20,6'h22,6'h3F,6'h0C};

  logic [23:0] exp_q[$];
  int          tag_q[$];
  int          total = 0;
  int          bad   = 0;
  logic        ill_model = 1'b0;

  // Expected control vector for one cycle of an instruction in a given step
  function automatic logic [23:0] model_vec(input int kind, input int st,
                                            input logic z, input logic ill,
                                            input logic last);
    logic       pw = 0, iw = 0, rw = 0, mw = 0, sa = 0, ir = 0;
    logic [1:0] ps = 0, rd = 0, mr = 0, sb = 0, ie = 0;
    logic [3:0] ac = 0;
    logic [2:0] s3;
    s3 = st[2:0];
    case (st)
      0: begin pw = 1; iw = 1; end
      1: ir = (kind == K_ILL);
      2: begin
        ac = alu_tab[kind];
        sa = (kind == 5 || kind == 6);
        sb = (kind >= 8) ? 2'd1 : 2'd0;
        ie = imm_tab[kind];
      end
      4: begin mw = 1; ir = last; end
      5: begin rw = 1; rd = (kind <= 6) ? 2'd1 : 2'd0; mr = (kind == K_LW) ? 2'd1 : 2'd0; ir = 1; end
      6: begin ac = 4'd1; ps = 2'd1; pw = z; ir = 1; end
      7: begin
        pw = 1; ps = (kind == K_JR) ? 2'd3 : 2'd2; ir = 1;
        if (kind == K_JAL) begin rw = 1; rd = 2'd2; mr = 2'd2; end
      end
      default: begin end
    endcase
    return {pw, ps, iw, rw, rd, mr, mw, sa, sb, ie, ac, s3, ir, ill};
  endfunction

  function automatic logic [23:0] dut_vec();
    return {pcWr, pcSrc, irWr, regWr, regDst, memtoReg, memWr, aluSrcA,
            aluSrcB, immExt, aluCtr, state, instRet, illegal};
  endfunction

  // Direct comparison used where the scoreboard is not in play (reset)
  task automatic check_output(input string name, input logic [23:0] exp);
    logic [23:0] act;
    act = dut_vec();
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%06h expected=%06h", name, act, exp);
    end
  endtask

  // Issue one instruction: push its expected cycles, then drive it through
  task automatic apply_stimulus(input int kind, input logic z, input int w, input int ill_sel);
    int   path[$];
    int   wait_cyc;
    logic [5:0] o, f;
    wait_cyc = 0;
`ifdef MC_CTRL_STALL_EN
    wait_cyc = w;
`endif
    o = op_tab[kind];
    f = (kind <= K_JR) ? fn_tab[kind] : 6'($urandom);
    if (kind == K_ILL && ill_sel >= 0) begin
      if (ill_sel < 5) o = bad_op[ill_sel];
      else begin o = 6'h00; f = bad_fn[ill_sel - 5]; end
    end
    path.push_back(0);
    path.push_back(1);
    if (kind == K_BEQ) path.push_back(6);
    else if (kind == K_JR || kind == K_J || kind == K_JAL) path.push_back(7);
    else if (kind != K_ILL) begin
      path.push_back(2);
      if (kind == K_LW) begin
        for (int i = 0; i <= wait_cyc; i++) path.push_back(3);
        path.push_back(5);
      end else if (kind == K_SW) begin
        for (int i = 0; i <= wait_cyc; i++) path.push_back(4);
      end else path.push_back(5);
    end
    op = o; funct = f; zero = z;
    for (int i = 0; i < path.size(); i++) begin
      exp_q.push_back(model_vec(kind, path[i], z, ill_model,
                                (i == path.size() - 1)));
      tag_q.push_back(kind * 16 + i);
    end
    for (int i = 0; i < path.size(); i++) begin
`ifdef MC_CTRL_STALL_EN
      memRdy = (i >= 3 + wait_cyc);
`else
      memRdy = 1'($urandom);
`endif
      @(posedge clk); #1;
    end
    if (kind == K_ILL) ill_model = 1'b1;
  endtask

  // Monitor: one expected vector per cycle, compared away from the clock edge
  always @(negedge clk) begin
    logic [23:0] e, a;
    int t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      a = dut_vec();
      total++;
      if (a !== e) begin
        bad++;
        $display("[TB] FAIL %s cycle %0d got=%06h expected=%06h",
                 nm_tab[t / 16], t % 16, a, e);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1; op = 6'h0; funct = 6'h0; zero = 1'b0; memRdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_output("reset_state", model_vec(0, 0, 1'b0, 1'b0, 1'b0));
    rst = 1'b0;

    // Directed pass over every instruction kind
    for (int k = 0; k <= K_ILL; k++) apply_stimulus(k, 1'b1, 3, 0);
    apply_stimulus(K_BEQ, 1'b0, 0, 0);
    apply_stimulus(K_SW, 1'b0, 3, 0);
    apply_stimulus(K_LW, 1'b1, 2, 0);

    // Randomized instruction stream
    for (int n = 0; n < 120; n++)
      apply_stimulus($urandom_range(0, K_ILL), 1'($urandom),
                     $urandom_range(0, 3), $urandom_range(0, 8));

    // Reset asserted in the middle of EXEC of an addu
    apply_stimulus(K_ILL, 1'b0, 0, 2);
    op = 6'h00; funct = 6'h21;
    exp_q.push_back(model_vec(0, 0, 1'b0, ill_model, 1'b0));
    tag_q.push_back(0);
    exp_q.push_back(model_vec(0, 1, 1'b0, ill_model, 1'b0));
    tag_q.push_back(1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_output("exec_before_reset", model_vec(0, 2, 1'b0, ill_model, 1'b0));
    #2 rst = 1'b1;
    #1 check_output("async_reset_mid_exec", model_vec(0, 0, 1'b0, 1'b0, 1'b0));
    @(posedge clk); #1;
    rst = 1'b0;
    ill_model = 1'b0;

    for (int n = 0; n < 40; n++)
      apply_stimulus($urandom_range(0, K_ILL - 1), 1'($urandom),
                     $urandom_range(0, 3), 0);

    @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL scoreboard_drain got=%0d expected=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
